simon_cfg_axil_master: RTL

- AXI4-Lite initiator for the Simon config register port. It is the master-side counterpart of the simon block's cfg slave.
- Accepts one register command at a time over a valid/ready command channel, runs the matching AXI4-Lite write or read, and returns the data and response over a valid/ready response channel.
- Used by PL-side sequencers and test harnesses to program keys, mode and control registers without the PS.

---
 rtl/simon_cfg_axil_master_if.sv | 43 ++++
 rtl/simon_cfg_axil_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/simon_cfg_axil_master_if.sv
// AXI4-Lite bus bundle between the Simon cfg master and the simon block's cfg slave.
interface simon_cfg_axil_master_if #(
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_PROT_WIDTH = 3,
    parameter int CFG_RESP_WIDTH = 2
);
    logic [CFG_ADDR_WIDTH-1:0]   awaddr;
    logic [CFG_PROT_WIDTH-1:0]   awprot;
    logic                        awvalid;
    logic                        awready;
    logic [CFG_DATA_WIDTH-1:0]   wdata;
    logic [CFG_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [CFG_RESP_WIDTH-1:0]   bresp;
    logic                        bvalid;
    logic                        bready;
    logic [CFG_ADDR_WIDTH-1:0]   araddr;
    logic [CFG_PROT_WIDTH-1:0]   arprot;
    logic                        arvalid;
    logic                        arready;
    logic [CFG_DATA_WIDTH-1:0]   rdata;
    logic [CFG_RESP_WIDTH-1:0]   rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/simon_cfg_axil_master.sv
// AXI4-Lite initiator: one valid/ready register command in, one AXI write or read out, one response back.
// Define SIMON_CFG_MASTER_TIMEOUT_EN to abort transactions stalled for TIMEOUT_CYCLES.
module simon_cfg_axil_master #(
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_STRB_WIDTH = CFG_DATA_WIDTH / 8,
    parameter int CFG_PROT_WIDTH = 3,
    parameter int CFG_RESP_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_simon_cfg,
    input  logic                      rst_simon_cfg,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [CFG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CFG_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [CFG_STRB_WIDTH-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [CFG_DATA_WIDTH-1:0] rsp_rdata,
    output logic [CFG_RESP_WIDTH-1:0] rsp_resp,
    output logic                      rsp_timeout,
    simon_cfg_axil_master_if.master   simon_cfg
);
    if (CFG_DATA_WIDTH != 32 && CFG_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("simon_cfg_axil_master: CFG_DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("simon_cfg_axil_master: TIMEOUT_CYCLES must fit the 16-bit stall counter");
    end

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_RSP} state_t;

    state_t                    r_state;
    logic [CFG_ADDR_WIDTH-1:0] r_addr;
    logic [CFG_DATA_WIDTH-1:0] r_wdata;
    logic [CFG_STRB_WIDTH-1:0] r_wstrb;
    logic                      r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
    logic                      r_aw_done, r_w_done;
    logic                      r_rsp_valid;
    logic [CFG_DATA_WIDTH-1:0] r_rdata;
    logic [CFG_RESP_WIDTH-1:0] r_resp;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_aw_fin, w_w_fin;

    assign w_aw_hs  = r_awvalid & simon_cfg.awready;
    assign w_w_hs   = r_wvalid & simon_cfg.wready;
    assign w_b_hs   = r_bready & simon_cfg.bvalid;
    assign w_ar_hs  = r_arvalid & simon_cfg.arready;
    assign w_r_hs   = r_rready & simon_cfg.rvalid;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

`ifdef SIMON_CFG_MASTER_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic        w_busy, w_any_hs, w_expired;

    // Valids/readies are low outside the waiting states, so any handshake here belongs to them.
    assign w_busy    = (r_state == S_WR) || (r_state == S_WR_B) ||
                       (r_state == S_RD_AR) || (r_state == S_RD_R);
    assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign w_expired = w_busy & ~w_any_hs & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = r_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready         = (r_state == S_IDLE);
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rdata;
    assign rsp_resp          = r_resp;
    assign simon_cfg.awaddr  = r_addr;
    assign simon_cfg.awprot  = {CFG_PROT_WIDTH{1'b0}};
    assign simon_cfg.awvalid = r_awvalid;
    assign simon_cfg.wdata   = r_wdata;
    assign simon_cfg.wstrb   = r_wstrb;
    assign simon_cfg.wvalid  = r_wvalid;
    assign simon_cfg.bready  = r_bready;
    assign simon_cfg.araddr  = r_addr;
    assign simon_cfg.arprot  = {CFG_PROT_WIDTH{1'b0}};
    assign simon_cfg.arvalid = r_arvalid;
    assign simon_cfg.rready  = r_rready;

    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_resp      <= '0;
`ifdef SIMON_CFG_MASTER_TIMEOUT_EN
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef SIMON_CFG_MASTER_TIMEOUT_EN
            r_cnt <= (w_busy && !w_any_hs) ? r_cnt + 16'd1 : 16'd0;
            if (w_expired) begin
                // Hung responder: drop everything and report a synthetic SLVERR.
                r_awvalid   <= 1'b0;
                r_wvalid    <= 1'b0;
                r_arvalid   <= 1'b0;
                r_bready    <= 1'b0;
                r_rready    <= 1'b0;
                r_rdata     <= '0;
                r_resp      <= CFG_RESP_WIDTH'(2'b10);
                r_timeout   <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RSP;
            end else
`endif
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
`ifdef SIMON_CFG_MASTER_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_AR;
                        end
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (w_b_hs) begin
                        r_bready    <= 1'b0;
                        r_resp      <= simon_cfg.bresp;
                        r_rdata     <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rdata     <= simon_cfg.rdata;
                        r_resp      <= simon_cfg.rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
